// File: rtl/spectrum_bar_renderer_if.sv
// Bin-magnitude write port between the sliding-DFT stage and the bar renderer.
// The producer holds bin_valid with index/magnitude until bin_ready is seen.
interface spectrum_bar_renderer_if #(
  parameter int NUM_BINS  = 16,
  parameter int MAG_WIDTH = 16,
  parameter int IDX_W     = $clog2(NUM_BINS)
);
  logic                 bin_valid;
  logic                 bin_ready;
  logic [IDX_W-1:0]     bin_index;
  logic [MAG_WIDTH-1:0] bin_mag;

  modport master (output bin_valid, bin_index, bin_mag, input bin_ready);
  modport slave  (input bin_valid, bin_index, bin_mag, output bin_ready);
endinterface

// File: rtl/spectrum_bar_renderer.sv
// Spectrum bar renderer: double-buffered bin magnitudes drawn as horizontal
// bars on the VGA raster, with a per-bin peak-hold marker that is held for a
// number of frames and then decays linearly. The display bank is refreshed
// only at the vsync rising edge, followed by a one-bin-per-clock peak sweep.
module spectrum_bar_renderer #(
  parameter int NUM_BINS    = 16,
  parameter int MAG_WIDTH   = 16,
  parameter int SHIFT       = 0,
  parameter int Y0          = 0,
  parameter int BAR_PITCH   = 10,
  parameter int BAR_HEIGHT  = 9,
  parameter int HOLD_FRAMES = 30,
  parameter int DECAY       = 4,
  parameter int IDX_W       = $clog2(NUM_BINS)
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       px_en,
  input  logic [9:0] x_px,
  input  logic [9:0] y_px,
  input  logic       activevideo,
  input  logic       vsync,
  spectrum_bar_renderer_if.slave bin_if,
  output logic       swap_done,
  output logic       r,
  output logic       g,
  output logic       b
);

  localparam int BW = (NUM_BINS > 1) ? $clog2(NUM_BINS) : 1;
  localparam int HW = $clog2(HOLD_FRAMES + 1);

  typedef enum logic [1:0] {IDLE, SWEEP, DONE} state_t;

  state_t state, next_state;

  logic [MAG_WIDTH-1:0] shadow  [NUM_BINS];
  logic [MAG_WIDTH-1:0] display [NUM_BINS];
  logic [MAG_WIDTH-1:0] peak    [NUM_BINS];
  logic [HW-1:0]        hold    [NUM_BINS];

  logic          vsync_q;
  logic          vsync_rise;
  logic          swap;
  logic          wr_en;
  logic [BW-1:0] sweep_idx;
  logic          sweep_last;

  logic [MAG_WIDTH-1:0] cur_disp, cur_peak, dec_peak, new_peak;
  logic [HW-1:0]        cur_hold;

  logic [9:0]  line_bin, line_row, cur_bin, cur_row;
  logic        above_y0, lit;
  logic [MAG_WIDTH-1:0] sel_mag, sel_peak;
  logic [31:0] sh_mag, sh_peak;
  logic [9:0]  bar_len, peak_pos;

  assign vsync_rise = vsync && !vsync_q;
  assign swap       = (state == IDLE) && vsync_rise;
  assign wr_en      = bin_if.bin_valid && bin_if.bin_ready;
  assign sweep_last = (sweep_idx == BW'(NUM_BINS - 1));

  // State register for the swap/sweep controller
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Next state: a vsync edge only starts a sweep from IDLE; edges seen later are dropped
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (vsync_rise) next_state = SWEEP;
      SWEEP:   if (sweep_last) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Controller outputs: writes only in IDLE outside the swap cycle, done pulse in DONE
  always_comb begin
    bin_if.bin_ready = 1'b0;
    swap_done        = 1'b0;
    case (state)
      IDLE:    bin_if.bin_ready = !reset && !vsync_rise;
      DONE:    swap_done = !reset;
      default: ;
    endcase
  end

  // Current bin fetched for the peak sweep, plus its decayed peak candidate
  always_comb begin
    cur_disp = display[sweep_idx];
    cur_peak = peak[sweep_idx];
    cur_hold = hold[sweep_idx];
    dec_peak = (cur_peak >= MAG_WIDTH'(DECAY)) ? cur_peak - MAG_WIDTH'(DECAY) : '0;
    new_peak = (dec_peak > cur_disp) ? dec_peak : cur_disp;
  end

  // Bin banks: shadow writes, whole-bank copy at swap, peak/hold update during sweep
  always_ff @(posedge clk) begin
    if (reset) begin
      vsync_q   <= 1'b0;
      sweep_idx <= '0;
      for (int i = 0; i < NUM_BINS; i++) begin
        shadow[i]  <= '0;
        display[i] <= '0;
        peak[i]    <= '0;
        hold[i]    <= '0;
      end
    end else begin
      vsync_q <= vsync;
      for (int i = 0; i < NUM_BINS; i++) begin
        if (wr_en && (bin_if.bin_index == IDX_W'(i))) shadow[i] <= bin_if.bin_mag;
        if (swap) display[i] <= shadow[i];
      end
      if (swap) sweep_idx <= '0;
      if (state == SWEEP) begin
        sweep_idx <= sweep_idx + BW'(1);
        if (cur_disp >= cur_peak) begin
          peak[sweep_idx] <= cur_disp;
          hold[sweep_idx] <= HW'(HOLD_FRAMES);
        end else if (cur_hold != '0) begin
          hold[sweep_idx] <= cur_hold - HW'(1);
        end else begin
          peak[sweep_idx] <= new_peak;
        end
      end
    end
  end

  generate
    if (Y0 == 0) begin : g_y0_zero
      assign above_y0 = 1'b1;
    end else begin : g_y0_nonzero
      assign above_y0 = (y_px >= 10'(Y0));
    end
  endgenerate

  // Bin/row of the pixel being drawn: reload at Y0, step once at the start of each line
  always_comb begin
    cur_bin = line_bin;
    cur_row = line_row;
    if (y_px == 10'(Y0)) begin
      cur_bin = '0;
      cur_row = '0;
    end else if (x_px == '0) begin
      if (line_row == 10'(BAR_PITCH - 1)) begin
        cur_row = '0;
        cur_bin = line_bin + 10'd1;
      end else begin
        cur_row = line_row + 10'd1;
      end
    end
  end

  // Line counters remember the bin/row of the last pixel drawn
  always_ff @(posedge clk) begin
    if (reset) begin
      line_bin <= '0;
      line_row <= '0;
    end else if (px_en) begin
      line_bin <= cur_bin;
      line_row <= cur_row;
    end
  end

  // Select the bar's magnitude and peak, then scale and clamp to the 10-bit raster
  always_comb begin
    sel_mag  = '0;
    sel_peak = '0;
    for (int i = 0; i < NUM_BINS; i++) begin
      if (cur_bin == 10'(i)) begin
        sel_mag  = display[i];
        sel_peak = peak[i];
      end
    end
    sh_mag   = 32'(sel_mag) >> SHIFT;
    sh_peak  = 32'(sel_peak) >> SHIFT;
    bar_len  = (sh_mag  > 32'd1023) ? 10'd1023 : sh_mag[9:0];
    peak_pos = (sh_peak > 32'd1023) ? 10'd1023 : sh_peak[9:0];
    lit      = above_y0 && (cur_bin < 10'(NUM_BINS)) && (cur_row < 10'(BAR_HEIGHT));
  end

  // Registered pixel colour, updated only on pixel-clock enables; the marker beats the bar
  always_ff @(posedge clk) begin
    if (reset) begin
      r <= 1'b0;
      g <= 1'b0;
      b <= 1'b0;
    end else if (px_en) begin
      if (!activevideo || !lit) begin
        {r, g, b} <= 3'b000;
      end else if ((x_px == peak_pos) && (peak_pos != '0)) begin
        {r, g, b} <= 3'b100;
      end else if (x_px < bar_len) begin
        {r, g, b} <= 3'b111;
      end else begin
        {r, g, b} <= 3'b000;
      end
    end
  end

endmodule
